instr_fetch: RTL and testbench

Instruction fetch stage that sits directly upstream of the 128x32 instruction memory. It owns the program counter, drives the memory address and read enable, and captures the returned word into the IF/ID pipeline register for decode. It also handles stalls from hazard detection, branch/jump redirects, pipeline flushes and a halt instruction.

---
 rtl/instr_fetch_if.sv | 16 +
 rtl/instr_fetch.sv | 98 +++++++++
 tb/tb_instr_fetch.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Instruction-memory bus between the fetch stage and the 128x32 instruction
// memory.
//   imem_adx   : word address (fetch -> memory)
//   imem_WrEn  : read enable, 1 = read (fetch -> memory)
//   imem_data  : instruction word, combinational read (memory -> fetch)
interface instr_fetch_if #(
    parameter int ADX_LENGTH = 7,
    parameter int DATA_WIDTH = 32
);
    logic [ADX_LENGTH-1:0] imem_adx;
    logic                  imem_WrEn;
    logic [DATA_WIDTH-1:0] imem_data;

    modport master (output imem_adx, output imem_WrEn, input  imem_data);
    modport slave  (input  imem_adx, input  imem_WrEn, output imem_data);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage. Owns the PC, drives the instruction memory and
// captures the returned word into the IF/ID pipeline register.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   imem            : instruction-memory bus (master side)
//   stall           : hold PC and IF/ID
//   flush           : turn IF/ID into a bubble
//   branch_taken    : redirect PC to branch_target (highest priority)
//   if_id_instr/pc1/valid : IF/ID pipeline register
//   halted          : fetch stopped on a halt word
//   fetch_count     : saturating count of valid instructions issued
module instr_fetch #(
    parameter int                       ADX_LENGTH = 7,
    parameter int                       DATA_WIDTH = 32,
    parameter int                       RESET_PC   = 0,
    parameter logic [DATA_WIDTH-1:0]    HALT_WORD  = 32'hFFFFFFFF,
    parameter int                       CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_fetch_if.master         imem,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  branch_taken,
    input  logic [ADX_LENGTH-1:0] branch_target,
    output logic [DATA_WIDTH-1:0] if_id_instr,
    output logic [ADX_LENGTH-1:0] if_id_pc1,
    output logic                  if_id_valid,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  fetch_count
);

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t                state, state_nxt;
    logic [ADX_LENGTH-1:0] pc, pc_nxt, pc_inc;
    logic [DATA_WIDTH-1:0] instr_nxt;
    logic [ADX_LENGTH-1:0] pc1_nxt;
    logic                  valid_nxt;
    logic [CNT_WIDTH-1:0]  cnt_nxt;

    assign imem.imem_adx  = pc;
    assign imem.imem_WrEn = 1'b1;
    assign halted         = (state == S_HALT);
    // Natural overflow of the ADX_LENGTH-bit add gives the 127 -> 0 wrap.
    assign pc_inc         = pc + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_RUN;
            pc          <= ADX_LENGTH'(RESET_PC);
            if_id_instr <= '0;
            if_id_pc1   <= '0;
            if_id_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            if_id_instr <= instr_nxt;
            if_id_pc1   <= pc1_nxt;
            if_id_valid <= valid_nxt;
            fetch_count <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = if_id_instr;
        pc1_nxt   = if_id_pc1;
        valid_nxt = if_id_valid;
        cnt_nxt   = fetch_count;

        if (branch_taken) begin
            // Redirect wins over everything; the word in flight is wrong-path.
            state_nxt = S_RUN;
            pc_nxt    = branch_target;
            instr_nxt = '0;
            valid_nxt = 1'b0;
        end else if (state == S_HALT) begin
            instr_nxt = '0;
            valid_nxt = 1'b0;
        end else if (flush) begin
            instr_nxt = '0;
            valid_nxt = 1'b0;
            if (!stall) pc_nxt = pc_inc;
        end else if (!stall) begin
            instr_nxt = imem.imem_data;
            pc1_nxt   = pc_inc;
            valid_nxt = 1'b1;
            if (!(&fetch_count)) cnt_nxt = fetch_count + 1'b1;
            // The halt word itself is issued; the PC parks on its address.
            if (imem.imem_data == HALT_WORD) state_nxt = S_HALT;
            else                             pc_nxt    = pc_inc;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    localparam int          AW   = 7;
    localparam int          DW   = 32;
    localparam int          CW   = 4;   // small so saturation is reached
    localparam int          CMAX = (1 << CW) - 1;
    localparam logic [31:0] HALT = 32'hFFFFFFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0, flush = 1'b0, branch_taken = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic [DW-1:0] if_id_instr;
    logic [AW-1:0] if_id_pc1;
    logic          if_id_valid, halted;
    logic [CW-1:0] fetch_count;
    logic [31:0]   mem [128];

    int errors = 0;
    int checks = 0;

    instr_fetch_if #(.ADX_LENGTH(AW), .DATA_WIDTH(DW)) bus ();
    assign bus.imem_data = mem[bus.imem_adx];

    instr_fetch #(.ADX_LENGTH(AW), .DATA_WIDTH(DW), .RESET_PC(0),
                  .HALT_WORD(HALT), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .imem(bus), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .if_id_instr(if_id_instr), .if_id_pc1(if_id_pc1),
        .if_id_valid(if_id_valid), .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: behaviour of the fetch stage stated directly as rules
    // on integer PC / counter values and the memory contents.
    int          m_pc, m_pc1, m_cnt;
    logic [31:0] m_instr;
    bit          m_valid, m_halted;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 0; m_pc1 = 0; m_cnt = 0; m_instr = 0; m_valid = 0; m_halted = 0;
        end else if (branch_taken) begin
            m_pc = int'(branch_target); m_instr = 0; m_valid = 0; m_halted = 0;
        end else if (m_halted) begin
            m_instr = 0; m_valid = 0;
        end else if (flush) begin
            m_instr = 0; m_valid = 0;
            if (!stall) m_pc = (m_pc + 1) % 128;
        end else if (!stall) begin
            m_instr = mem[m_pc];
            m_pc1   = (m_pc + 1) % 128;
            m_valid = 1;
            if (m_cnt < CMAX) m_cnt++;
            if (mem[m_pc] == HALT) m_halted = 1;
            else m_pc = (m_pc + 1) % 128;
        end
    end

    always @(negedge clk) begin
        check("imem_adx",    32'(bus.imem_adx), 32'(m_pc));
        check("imem_WrEn",   32'(bus.imem_WrEn), 32'd1);
        check("if_id_instr", if_id_instr, m_instr);
        check("if_id_pc1",   32'(if_id_pc1), 32'(m_pc1));
        check("if_id_valid", 32'(if_id_valid), 32'(m_valid));
        check("halted",      32'(halted), 32'(m_halted));
        check("fetch_count", 32'(fetch_count), 32'(m_cnt));
    end

    // Inputs change just after the falling edge, away from both the compare
    // and the active edge.
    task automatic drv(input logic b, input int t, input logic s, input logic f);
        @(negedge clk); #1;
        branch_taken = b; branch_target = AW'(t); stall = s; flush = f;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        for (int k = 0; k < 128; k++) mem[k] = k;

        // Reset state, including WrEn held high during reset.
        repeat (2) @(negedge clk);
        check("rst adx", 32'(bus.imem_adx), 0);
        check("rst valid", 32'(if_id_valid), 0);
        check("rst count", 32'(fetch_count), 0);
        check("rst wren", 32'(bus.imem_WrEn), 1);
        @(negedge clk); #1; rst = 1'b0;

        // Sequential fetch.
        tick();
        check("seq first instr", if_id_instr, 0);
        check("seq first pc1", 32'(if_id_pc1), 1);
        repeat (4) tick();
        check("seq instr", if_id_instr, 4);
        check("seq pc1", 32'(if_id_pc1), 5);
        check("seq count", 32'(fetch_count), 5);

        // Wrap-around.
        drv(1, 126, 0, 0); tick();
        check("wrap adx126", 32'(bus.imem_adx), 126);
        check("wrap bubble", 32'(if_id_valid), 0);
        drv(0, 0, 0, 0); tick();
        check("wrap adx127", 32'(bus.imem_adx), 127);
        tick();
        check("wrap adx0", 32'(bus.imem_adx), 0);
        check("wrap instr127", if_id_instr, 127);
        check("wrap pc1", 32'(if_id_pc1), 0);

        // Stall at pc=4 after a valid fetch of word 3.
        drv(1, 2, 0, 0); tick();
        drv(0, 0, 0, 0); tick(); tick();
        drv(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall adx", 32'(bus.imem_adx), 4);
            check("stall instr", if_id_instr, 3);
            check("stall valid", 32'(if_id_valid), 1);
        end
        drv(0, 0, 0, 0); tick();
        check("stall resume", if_id_instr, 4);
        tick();
        check("stall next", if_id_instr, 5);

        // Branch with simultaneous stall and flush.
        drv(1, 10, 0, 0); tick();
        drv(1, 40, 1, 1); tick();
        check("brsf adx", 32'(bus.imem_adx), 40);
        check("brsf valid", 32'(if_id_valid), 0);
        drv(0, 0, 0, 0); tick();
        check("brsf instr", if_id_instr, 40);
        check("brsf valid2", 32'(if_id_valid), 1);

        // Halt at address 6, then branch out.
        drv(1, 0, 0, 0); mem[6] = HALT; tick();
        drv(0, 0, 0, 0);
        repeat (6) tick();
        check("halt pc", 32'(bus.imem_adx), 6);
        tick();
        check("halt word", if_id_instr, HALT);
        check("halt word valid", 32'(if_id_valid), 1);
        check("halted", 32'(halted), 1);
        drv(0, 0, 1, 1); tick();
        check("halt bubble", 32'(if_id_valid), 0);
        check("halt adx", 32'(bus.imem_adx), 6);
        tick();
        check("halt hold", 32'(bus.imem_adx), 6);
        drv(1, 0, 0, 0); tick();
        check("unhalt", 32'(halted), 0);
        check("unhalt adx", 32'(bus.imem_adx), 0);
        drv(0, 0, 0, 0); mem[6] = 6; tick();
        check("unhalt instr valid", 32'(if_id_valid), 1);

        // Async reset between edges at pc=20.
        drv(1, 17, 0, 0); tick();
        drv(0, 0, 0, 0); repeat (3) tick();
        check("pre-reset adx", 32'(bus.imem_adx), 20);
        #2 rst = 1'b1;
        #1;
        check("async adx", 32'(bus.imem_adx), 0);
        check("async valid", 32'(if_id_valid), 0);
        check("async count", 32'(fetch_count), 0);
        @(negedge clk); #1; rst = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if ($urandom_range(0, 3) == 0)
                mem[$urandom_range(0, 127)] = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
            stall         = ($urandom_range(0, 3) == 0);
            flush         = ($urandom_range(0, 5) == 0);
            branch_taken  = ($urandom_range(0, 9) == 0);
            branch_target = AW'($urandom_range(0, 127));
            rst           = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk); #1;
        rst = 0; stall = 0; flush = 0; branch_taken = 0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
